// File: rtl/up_ipif_demux.sv
// up_ipif_demux: routes one up_wr/up_rd request stream to 2^C_SEL_WIDTH register
// slaves, selected by the top C_SEL_WIDTH bits of the word address. It returns the
// selected slave's ack, and its read data for reads. Each channel has a timeout so
// that a missing or hung slave still produces an ack.
//
// Ports:
//   aclk, areset                    clock, synchronous active-high reset
//   up_wr_* / up_rd_*               bridge side: one-cycle req in, one-cycle ack out
//   slv_wr_* / slv_rd_*             slave side: shared addr/be/din, one-hot req,
//                                   per-slave ack and read data
//   wr_timeout / rd_timeout         pulse with the up ack when that ack was a timeout
module up_ipif_demux #(
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_SEL_WIDTH  = 2,
  parameter int unsigned C_TIMEOUT    = 255,
  parameter logic [C_DATA_WIDTH-1:0] C_TIMEOUT_DATA = C_DATA_WIDTH'(32'hDEAD_BEEF),
  localparam int unsigned UAW = C_ADDR_WIDTH - 2,
  localparam int unsigned N   = 1 << C_SEL_WIDTH,
  localparam int unsigned AW  = UAW - C_SEL_WIDTH,
  localparam int unsigned DW  = C_DATA_WIDTH
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [UAW-1:0]  up_wr_addr,
  input  logic            up_wr_req,
  input  logic [3:0]      up_wr_be,
  input  logic [DW-1:0]   up_wr_din,
  output logic            up_wr_ack,
  input  logic [UAW-1:0]  up_rd_addr,
  input  logic            up_rd_req,
  output logic [DW-1:0]   up_rd_dout,
  output logic            up_rd_ack,
  output logic [AW-1:0]   slv_wr_addr,
  output logic [N-1:0]    slv_wr_req,
  output logic [3:0]      slv_wr_be,
  output logic [DW-1:0]   slv_wr_din,
  input  logic [N-1:0]    slv_wr_ack,
  output logic [AW-1:0]   slv_rd_addr,
  output logic [N-1:0]    slv_rd_req,
  input  logic [N*DW-1:0] slv_rd_dout,
  input  logic [N-1:0]    slv_rd_ack,
  output logic            wr_timeout,
  output logic            rd_timeout
);

  localparam int unsigned CW = 16;

  typedef enum logic {IDLE, BUSY} state_t;

  // write channel registers and next values
  state_t                 wr_state, wr_state_nx;
  logic [CW-1:0]          wr_cnt, wr_cnt_nx;
  logic [C_SEL_WIDTH-1:0] wr_sel, wr_sel_nx;
  logic [AW-1:0]          slv_wr_addr_nx;
  logic [N-1:0]           slv_wr_req_nx;
  logic [3:0]             slv_wr_be_nx;
  logic [DW-1:0]          slv_wr_din_nx;
  logic                   up_wr_ack_nx, wr_timeout_nx;

  // read channel registers and next values
  state_t                 rd_state, rd_state_nx;
  logic [CW-1:0]          rd_cnt, rd_cnt_nx;
  logic [C_SEL_WIDTH-1:0] rd_sel, rd_sel_nx;
  logic [AW-1:0]          slv_rd_addr_nx;
  logic [N-1:0]           slv_rd_req_nx;
  logic [DW-1:0]          up_rd_dout_nx;
  logic                   up_rd_ack_nx, rd_timeout_nx;

  // per-slave view of the flattened read data bus
  logic [DW-1:0] rd_slice [N];
  for (genvar i = 0; i < N; i++) begin : g_slice
    assign rd_slice[i] = slv_rd_dout[i*DW +: DW];
  end

  // write channel next-state/outputs
  always_comb begin
    wr_state_nx    = wr_state;
    wr_cnt_nx      = wr_cnt;
    wr_sel_nx      = wr_sel;
    slv_wr_addr_nx = slv_wr_addr;
    slv_wr_be_nx   = slv_wr_be;
    slv_wr_din_nx  = slv_wr_din;
    slv_wr_req_nx  = '0;
    up_wr_ack_nx   = 1'b0;
    wr_timeout_nx  = 1'b0;
    unique case (wr_state)
      IDLE: begin
        if (up_wr_req) begin
          wr_sel_nx      = up_wr_addr[UAW-1 -: C_SEL_WIDTH];
          slv_wr_addr_nx = up_wr_addr[AW-1:0];
          slv_wr_be_nx   = up_wr_be;
          slv_wr_din_nx  = up_wr_din;
          slv_wr_req_nx  = N'(1) << up_wr_addr[UAW-1 -: C_SEL_WIDTH];
          wr_cnt_nx      = '0;
          wr_state_nx    = BUSY;
        end
      end
      BUSY: begin
        // ack takes priority over a coincident timeout
        if (slv_wr_ack[wr_sel]) begin
          up_wr_ack_nx = 1'b1;
          wr_state_nx  = IDLE;
        end else if (wr_cnt == CW'(C_TIMEOUT)) begin
          up_wr_ack_nx  = 1'b1;
          wr_timeout_nx = 1'b1;
          wr_state_nx   = IDLE;
        end else begin
          wr_cnt_nx = wr_cnt + CW'(1);
        end
      end
      default: wr_state_nx = IDLE;
    endcase
  end

  // read channel next-state/outputs
  always_comb begin
    rd_state_nx    = rd_state;
    rd_cnt_nx      = rd_cnt;
    rd_sel_nx      = rd_sel;
    slv_rd_addr_nx = slv_rd_addr;
    up_rd_dout_nx  = up_rd_dout;
    slv_rd_req_nx  = '0;
    up_rd_ack_nx   = 1'b0;
    rd_timeout_nx  = 1'b0;
    unique case (rd_state)
      IDLE: begin
        if (up_rd_req) begin
          rd_sel_nx      = up_rd_addr[UAW-1 -: C_SEL_WIDTH];
          slv_rd_addr_nx = up_rd_addr[AW-1:0];
          slv_rd_req_nx  = N'(1) << up_rd_addr[UAW-1 -: C_SEL_WIDTH];
          rd_cnt_nx      = '0;
          rd_state_nx    = BUSY;
        end
      end
      BUSY: begin
        if (slv_rd_ack[rd_sel]) begin
          up_rd_ack_nx  = 1'b1;
          up_rd_dout_nx = rd_slice[rd_sel];
          rd_state_nx   = IDLE;
        end else if (rd_cnt == CW'(C_TIMEOUT)) begin
          up_rd_ack_nx  = 1'b1;
          rd_timeout_nx = 1'b1;
          up_rd_dout_nx = C_TIMEOUT_DATA;
          rd_state_nx   = IDLE;
        end else begin
          rd_cnt_nx = rd_cnt + CW'(1);
        end
      end
      default: rd_state_nx = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state    <= IDLE;
      wr_cnt      <= '0;
      wr_sel      <= '0;
      slv_wr_addr <= '0;
      slv_wr_req  <= '0;
      slv_wr_be   <= '0;
      slv_wr_din  <= '0;
      up_wr_ack   <= 1'b0;
      wr_timeout  <= 1'b0;
      rd_state    <= IDLE;
      rd_cnt      <= '0;
      rd_sel      <= '0;
      slv_rd_addr <= '0;
      slv_rd_req  <= '0;
      up_rd_dout  <= '0;
      up_rd_ack   <= 1'b0;
      rd_timeout  <= 1'b0;
    end else begin
      wr_state    <= wr_state_nx;
      wr_cnt      <= wr_cnt_nx;
      wr_sel      <= wr_sel_nx;
      slv_wr_addr <= slv_wr_addr_nx;
      slv_wr_req  <= slv_wr_req_nx;
      slv_wr_be   <= slv_wr_be_nx;
      slv_wr_din  <= slv_wr_din_nx;
      up_wr_ack   <= up_wr_ack_nx;
      wr_timeout  <= wr_timeout_nx;
      rd_state    <= rd_state_nx;
      rd_cnt      <= rd_cnt_nx;
      rd_sel      <= rd_sel_nx;
      slv_rd_addr <= slv_rd_addr_nx;
      slv_rd_req  <= slv_rd_req_nx;
      up_rd_dout  <= up_rd_dout_nx;
      up_rd_ack   <= up_rd_ack_nx;
      rd_timeout  <= rd_timeout_nx;
    end
  end

endmodule

// File: tb/tb_up_ipif_demux.sv
// Bench for up_ipif_demux: latency-programmable slave models, a scoreboard of expected
// up-side acks (cycle, data, timeout flag) and directed checks of the slave-side request.
module tb_up_ipif_demux;

  localparam int TO = 8;

  logic         aclk = 1'b0;
  logic         areset;
  logic [9:0]   up_wr_addr, up_rd_addr;
  logic         up_wr_req, up_rd_req;
  logic [3:0]   up_wr_be;
  logic [31:0]  up_wr_din;
  logic         up_wr_ack, up_rd_ack;
  logic [31:0]  up_rd_dout;
  logic [7:0]   slv_wr_addr, slv_rd_addr;
  logic [3:0]   slv_wr_req, slv_rd_req, slv_wr_ack, slv_rd_ack;
  logic [3:0]   slv_wr_be;
  logic [31:0]  slv_wr_din;
  logic [127:0] slv_rd_dout;
  logic         wr_timeout, rd_timeout;

  up_ipif_demux #(.C_TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .up_wr_addr(up_wr_addr), .up_wr_req(up_wr_req), .up_wr_be(up_wr_be),
    .up_wr_din(up_wr_din), .up_wr_ack(up_wr_ack),
    .up_rd_addr(up_rd_addr), .up_rd_req(up_rd_req), .up_rd_dout(up_rd_dout),
    .up_rd_ack(up_rd_ack),
    .slv_wr_addr(slv_wr_addr), .slv_wr_req(slv_wr_req), .slv_wr_be(slv_wr_be),
    .slv_wr_din(slv_wr_din), .slv_wr_ack(slv_wr_ack),
    .slv_rd_addr(slv_rd_addr), .slv_rd_req(slv_rd_req), .slv_rd_dout(slv_rd_dout),
    .slv_rd_ack(slv_rd_ack),
    .wr_timeout(wr_timeout), .rd_timeout(rd_timeout)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // slave models: lat 0 = ack with req, lat L>0 = ack L cycles after req, lat<0 = never
  int          wr_lat [4];
  int          rd_lat [4];
  int          wr_cd  [4];
  int          rd_cd  [4];
  logic [31:0] rd_data [4];
  logic [3:0]  spur_wr_ack, spur_rd_ack;

  always @(posedge aclk) begin
    for (int i = 0; i < 4; i++) begin
      if (slv_wr_req[i] && wr_lat[i] > 0) wr_cd[i] <= wr_lat[i];
      else if (wr_cd[i] > 0)              wr_cd[i] <= wr_cd[i] - 1;
      if (slv_rd_req[i] && rd_lat[i] > 0) rd_cd[i] <= rd_lat[i];
      else if (rd_cd[i] > 0)              rd_cd[i] <= rd_cd[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slv_wr_ack[i] = spur_wr_ack[i] | (slv_wr_req[i] && wr_lat[i] == 0) | (wr_cd[i] == 1);
      slv_rd_ack[i] = spur_rd_ack[i] | (slv_rd_req[i] && rd_lat[i] == 0) | (rd_cd[i] == 1);
      slv_rd_dout[i*32 +: 32] = rd_data[i];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          to;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];

  // scoreboard side: every up ack must match the oldest expectation
  always @(negedge aclk) begin
    exp_t e;
    if (up_wr_ack) begin
      if (wr_q.size() == 0) check("wr_unexpected_ack", 1, 0);
      else begin
        e = wr_q.pop_front();
        check("wr_ack_cycle", 64'(cyc), 64'(e.cyc));
        check("wr_timeout_flag", 64'(wr_timeout), 64'(e.to));
      end
    end else if (wr_timeout) check("wr_stray_timeout", 1, 0);
    if (up_rd_ack) begin
      if (rd_q.size() == 0) check("rd_unexpected_ack", 1, 0);
      else begin
        e = rd_q.pop_front();
        check("rd_ack_cycle", 64'(cyc), 64'(e.cyc));
        check("rd_data", 64'(up_rd_dout), 64'(e.data));
        check("rd_timeout_flag", 64'(rd_timeout), 64'(e.to));
      end
    end else if (rd_timeout) check("rd_stray_timeout", 1, 0);
  end

  // drivers: set the request inputs for the current cycle and push the expectation
  task automatic drive_wr(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d,
                          input bit accept);
    int   s;
    exp_t e;
    up_wr_addr = a; up_wr_be = be; up_wr_din = d; up_wr_req = 1'b1;
    if (accept) begin
      s = int'(a[9:8]);
      e.data = '0;
      if (wr_lat[s] >= 0 && wr_lat[s] <= TO) begin e.cyc = cyc + 2 + wr_lat[s]; e.to = 1'b0; end
      else begin e.cyc = cyc + 2 + TO; e.to = 1'b1; end
      wr_q.push_back(e);
    end
  endtask

  task automatic drive_rd(input logic [9:0] a);
    int   s;
    exp_t e;
    up_rd_addr = a; up_rd_req = 1'b1;
    s = int'(a[9:8]);
    if (rd_lat[s] >= 0 && rd_lat[s] <= TO) begin
      e.cyc = cyc + 2 + rd_lat[s]; e.data = rd_data[s]; e.to = 1'b0;
    end else begin
      e.cyc = cyc + 2 + TO; e.data = 32'hDEAD_BEEF; e.to = 1'b1;
    end
    rd_q.push_back(e);
  endtask

  task automatic step();
    @(posedge aclk); #1;
    up_wr_req = 1'b0;
    up_rd_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (wr_q.size() == 0 && rd_q.size() == 0) break;
    end
    check(tag, 64'(wr_q.size() + rd_q.size()), 0);
    wr_q.delete();
    rd_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      wr_lat[i] = 1; rd_lat[i] = 1; wr_cd[i] = 0; rd_cd[i] = 0; rd_data[i] = '0;
    end
    spur_wr_ack = '0; spur_rd_ack = '0;
    up_wr_addr = '0; up_wr_req = 1'b0; up_wr_be = '0; up_wr_din = '0;
    up_rd_addr = '0; up_rd_req = 1'b0;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // reset state
    @(negedge aclk);
    check("rst_outputs", {up_wr_ack, up_rd_ack, wr_timeout, rd_timeout, slv_wr_req, slv_rd_req}, 0);
    check("rst_rd_dout", 64'(up_rd_dout), 0);
    check("rst_slv_wr", {slv_wr_addr, slv_wr_be, slv_wr_din, slv_rd_addr}, 0);

    // write to slave 2, ack 3 cycles after slave req
    wr_lat[2] = 3;
    @(posedge aclk); #1;
    drive_wr(10'h2A5, 4'hF, 32'h1234_5678, 1'b1);
    step();
    @(negedge aclk);
    check("wr_slv_req", 64'(slv_wr_req), 64'(4'b0100));
    check("wr_slv_addr", 64'(slv_wr_addr), 64'(8'hA5));
    check("wr_slv_be_din", {slv_wr_be, slv_wr_din}, {4'hF, 32'h1234_5678});
    @(negedge aclk);
    check("wr_slv_req_pulse", 64'(slv_wr_req), 0);
    wait_idle("wr_done", 20);

    // read slave 1 with same-cycle ack, while slave 3 acks spuriously
    rd_lat[1] = 0; rd_data[1] = 32'hCAFE_0001; rd_data[3] = 32'h3333_3333;
    spur_rd_ack[3] = 1'b1;
    @(posedge aclk); #1;
    drive_rd(10'h133);
    step();
    @(negedge aclk);
    check("rd_slv_req", 64'(slv_rd_req), 64'(4'b0010));
    check("rd_slv_addr", 64'(slv_rd_addr), 64'(8'h33));
    wait_idle("rd_same_cycle_done", 20);
    spur_rd_ack = '0;
    repeat (2) @(negedge aclk);
    check("rd_dout_hold", 64'(up_rd_dout), 64'(32'hCAFE_0001));

    // read slave 0 with no ack: timeout, then a normal read
    rd_lat[0] = -1;
    @(posedge aclk); #1;
    drive_rd(10'h010);
    step();
    wait_idle("rd_timeout_done", 30);
    rd_lat[0] = 1; rd_data[0] = 32'h0000_5A5A;
    @(posedge aclk); #1;
    drive_rd(10'h011);
    step();
    wait_idle("rd_after_timeout_done", 20);

    // concurrent write slave 0 and read slave 3, plus a dropped write
    wr_lat[0] = 5; rd_lat[3] = 2; rd_data[3] = 32'hBEEF_0003;
    @(posedge aclk); #1;
    drive_wr(10'h00C, 4'h3, 32'hAAAA_0000, 1'b1);
    drive_rd(10'h3C4);
    step();
    @(negedge aclk);
    check("cc_slv_wr_req", 64'(slv_wr_req), 64'(4'b0001));
    check("cc_slv_rd_req", 64'(slv_rd_req), 64'(4'b1000));
    check("cc_slv_rd_addr", 64'(slv_rd_addr), 64'(8'hC4));
    @(posedge aclk); #1;
    drive_wr(10'h1FF, 4'h1, 32'h5555_5555, 1'b0);
    step();
    @(negedge aclk);
    check("drop_slv_wr_req", 64'(slv_wr_req), 0);
    check("drop_slv_wr_addr", 64'(slv_wr_addr), 64'(8'h0C));
    wait_idle("concurrent_done", 30);

    // slave ack exactly on the timeout cycle: ack wins
    rd_lat[2] = TO; rd_data[2] = 32'h7777_0002;
    @(posedge aclk); #1;
    drive_rd(10'h2EE);
    step();
    wait_idle("ack_on_timeout_done", 30);

    // reset while write is busy: no ack, outputs back to reset values
    wr_lat[3] = -1;
    @(posedge aclk); #1;
    drive_wr(10'h3A0, 4'h8, 32'h0BAD_F00D, 1'b1);
    step();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b1;
    wr_q.delete();
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check("mid_rst_req_ack", {slv_wr_req, up_wr_ack, wr_timeout}, 0);
    check("mid_rst_slv_wr", {slv_wr_addr, slv_wr_be, slv_wr_din}, 0);
    check("mid_rst_rd_dout", 64'(up_rd_dout), 0);
    @(posedge aclk); #1 spur_wr_ack[3] = 1'b1;
    @(posedge aclk); #1 spur_wr_ack[3] = 1'b0;
    repeat (15) @(negedge aclk);
    check("post_rst_no_ack_queue", 64'(wr_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/up_ipif_demux.md
# up_ipif_demux

Address-decoding splitter between the AXI4-Lite-to-up_ipif bridge and the register slaves of a core. Accepts one up_wr/up_rd request stream and routes each request to one of 2^C_SEL_WIDTH slave ports, selected by the top bits of the word address. Returns that slave's acknowledge, and read data for reads, to the bridge. A per-channel timeout guarantees an acknowledge, so an absent or hung slave cannot stall the AXI bus.

## Interface
Parameters:
- C_ADDR_WIDTH, 12, byte address width; up-side word address is C_ADDR_WIDTH-2 bits
- C_DATA_WIDTH, 32, data width
- C_SEL_WIDTH, 2, slave select bits; N = 2^C_SEL_WIDTH slaves; slave word address is AW = C_ADDR_WIDTH-2-C_SEL_WIDTH bits
- C_TIMEOUT, 255, cycles to wait for a slave ack (1..65535)
- C_TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- up_wr_addr  in  C_ADDR_WIDTH-2  word address; bits [MSB -: C_SEL_WIDTH] select the slave
- up_wr_req  in  1  one-cycle write request pulse
- up_wr_be  in  4  byte enables
- up_wr_din  in  C_DATA_WIDTH  write data
- up_wr_ack  out  1  one-cycle write completion pulse
- up_rd_addr  in  C_ADDR_WIDTH-2  word address
- up_rd_req  in  1  one-cycle read request pulse
- up_rd_dout  out  C_DATA_WIDTH  read data, valid while up_rd_ack=1
- up_rd_ack  out  1  one-cycle read completion pulse
- slv_wr_addr  out  AW  shared write address
- slv_wr_req  out  N  one-hot write request pulse
- slv_wr_be  out  4  shared byte enables
- slv_wr_din  out  C_DATA_WIDTH  shared write data
- slv_wr_ack  in  N  per-slave write ack
- slv_rd_addr  out  AW  shared read address
- slv_rd_req  out  N  one-hot read request pulse
- slv_rd_dout  in  N*C_DATA_WIDTH  per-slave read data; slave i at [i*C_DATA_WIDTH +: C_DATA_WIDTH]
- slv_rd_ack  in  N  per-slave read ack
- wr_timeout  out  1  one-cycle pulse, coincident with up_wr_ack, when a write timed out
- rd_timeout  out  1  one-cycle pulse, coincident with up_rd_ack, when a read timed out

## Operation
- Write and read channels are independent, identical FSMs. They may be busy at the same time.
- Each FSM has two states: IDLE and BUSY.
- IDLE:
  - On req=1, register the select index, slave address, be and din.
  - Drive slv_*_req[sel] high for exactly the next cycle.
  - Clear the counter to 0 and go to BUSY.
- BUSY:
  - Each cycle, check slv_*_ack[sel] only. Acks on non-selected slaves are ignored.
  - On ack=1: register the ack (and for reads, slice sel of slv_rd_dout) to the up side, then go to IDLE.
  - On no ack: increment the counter.
  - When counter == C_TIMEOUT with no ack: pulse up_*_ack and *_timeout. For reads, up_rd_dout = C_TIMEOUT_DATA. Then go to IDLE.
- Ack and timeout in the same cycle: the ack wins; no timeout pulse.
- An up req arriving while that channel is BUSY is a protocol violation. It is dropped: no slave request, no ack.
- The counter is 16 bits and never wraps; it is cleared on each new request.
- Address, be and din outputs hold their last values between requests.
- up_rd_dout holds its last value when up_rd_ack=0.
- The downstream protocol is the same as the upstream one: req is one cycle with addr/din/be valid in that cycle; ack is one cycle with dout valid in that cycle.

## Timing
- Reset values: all req/ack/timeout outputs 0; slv_*_addr, slv_wr_be, slv_wr_din and up_rd_dout all 0; both FSMs IDLE; counters 0.
- An up req in cycle T produces slv req in cycle T+1.
- A slave ack in cycle T+k (k≥1, possibly the same cycle as slv req) produces up ack in cycle T+k+1.
- Minimum round trip is 2 cycles, when the slave acks in the same cycle as its req.
- Timeout: with slv req in cycle T+1 and no ack, up ack plus timeout pulse appear in cycle T+2+C_TIMEOUT.
- The earliest new request accepted is in the cycle of up ack.
- areset asserted mid-transaction: next edge forces IDLE with all outputs at reset values. No ack is emitted for the aborted request. A slave ack after reset is ignored.

## Test plan
- Write to slave 2, addr 10'h2A5 (sel=2, slave addr 8'hA5), be=4'hF, din=32'h1234_5678, slave acks 3 cycles after slv req -> slv_wr_req=4'b0100 for 1 cycle, slv_wr_addr=8'hA5, up_wr_ack 1 cycle after slave ack, wr_timeout=0.
- Read slave 1 (acks same cycle as req, dout 32'hCAFE_0001) while slave 3 drives a spurious ack -> up_rd_ack 2 cycles after up_rd_req, up_rd_dout=32'hCAFE_0001; spurious ack has no effect.
- Read slave 0, no ack, C_TIMEOUT=8 -> up_rd_ack and rd_timeout together in cycle T+10, up_rd_dout=32'hDEAD_BEEF; next read then completes normally.
- Concurrent write to slave 0 and read from slave 3 in the same cycle, with different ack latencies -> both complete independently with correct data; second up_wr_req while write BUSY is dropped.
- Slave ack arriving exactly on the timeout cycle -> normal ack with slave data and no timeout pulse. areset asserted while BUSY -> no ack; outputs return to reset values.
